param_counter: RTL and testbench



---
 rtl/param_counter.sv | 78 +++++++
 tb/tb_param_counter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/param_counter.sv
// WIDTH-bit up/down loop counter with a programmable terminal value, parallel load,
// an init value fixed at build time and wrap / saturate / one-shot behaviour at terminal.
module param_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned INIT_VAL = 2
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             cen,
  input  logic             iz,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             up,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] cnt_val,
  output logic             co,
  output logic             wrap,
  output logic             done
);

  localparam logic [WIDTH-1:0] INIT_W       = WIDTH'(INIT_VAL);
  localparam logic [WIDTH-1:0] ONE_W        = WIDTH'(1);
  localparam logic [1:0]       MODE_SAT     = 2'b01;
  localparam logic [1:0]       MODE_ONESHOT = 2'b10;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t state;
  logic   term_hit_c;

  // Values above term count as terminal when counting up.
  assign term_hit_c = up ? (cnt_val >= term) : (cnt_val == '0);
  assign co         = term_hit_c;
  assign done       = (state == HALT);

  // Priority per edge: iz, then ld, then an enabled count step.
  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      cnt_val <= '0;
      wrap    <= 1'b0;
      state   <= RUN;
    end else if (iz) begin
      cnt_val <= INIT_W;
      wrap    <= 1'b0;
      state   <= RUN;
    end else if (ld) begin
      cnt_val <= ld_val;
      wrap    <= 1'b0;
      state   <= RUN;
    end else if (cen && (state == RUN)) begin
      if (!term_hit_c) begin
        cnt_val <= up ? (cnt_val + ONE_W) : (cnt_val - ONE_W);
        wrap    <= 1'b0;
      end else begin
        case (mode)
          MODE_SAT: begin
            wrap <= 1'b0;
          end
          MODE_ONESHOT: begin
            wrap  <= 1'b1;
            state <= HALT;
          end
          default: begin
            cnt_val <= up ? '0 : term;
            wrap    <= 1'b1;
          end
        endcase
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_param_counter.sv
// Self-checking bench: a 4-bit legacy-config and an 8-bit counter driven in parallel,
// checked every cycle against a behavioural model plus directed literal expectations.
module tb_param_counter;

  logic       clk;
  logic       sclr;
  logic       cen;
  logic       iz;
  logic       ld;
  logic [7:0] ld_val;
  logic       up;
  logic [1:0] mode;
  logic [7:0] term;

  logic [3:0] cnt4;
  logic       co4, wrap4, done4;
  logic [7:0] cnt8;
  logic       co8, wrap8, done8;

  int tests = 0;
  int fails = 0;

  param_counter #(.WIDTH(4), .INIT_VAL(2)) u4 (
    .clk(clk), .sclr(sclr), .cen(cen), .iz(iz), .ld(ld), .ld_val(ld_val[3:0]),
    .up(up), .mode(mode), .term(term[3:0]),
    .cnt_val(cnt4), .co(co4), .wrap(wrap4), .done(done4)
  );

  // INIT_VAL of 300 truncates to 44 in 8 bits.
  param_counter #(.WIDTH(8), .INIT_VAL(300)) u8 (
    .clk(clk), .sclr(sclr), .cen(cen), .iz(iz), .ld(ld), .ld_val(ld_val),
    .up(up), .mode(mode), .term(term),
    .cnt_val(cnt8), .co(co8), .wrap(wrap8), .done(done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int cnt;
    bit halted;
    bit wr;
  } mstate_t;

  mstate_t m4 = '0;
  mstate_t m8 = '0;

  function automatic bit model_term(mstate_t s, int w);
    int md = 1 << w;
    int tv = int'(term) % md;
    return up ? (s.cnt >= tv) : (s.cnt == 0);
  endfunction

  function automatic mstate_t model_next(mstate_t s, int w, int init);
    int md = 1 << w;
    int tv = int'(term) % md;
    mstate_t n = s;
    bit t = model_term(s, w);
    n.wr = 1'b0;
    if (iz) begin
      n.cnt = init % md;
      n.halted = 1'b0;
    end else if (ld) begin
      n.cnt = int'(ld_val) % md;
      n.halted = 1'b0;
    end else if (cen && !s.halted) begin
      if (!t) n.cnt = up ? (s.cnt + 1) % md : (s.cnt + md - 1) % md;
      else if (mode == 2'd1) n.wr = 1'b0;
      else if (mode == 2'd2) begin
        n.halted = 1'b1;
        n.wr = 1'b1;
      end else begin
        n.cnt = up ? 0 : tv;
        n.wr = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge sclr) begin
    if (sclr) begin
      m4 <= '0;
      m8 <= '0;
    end else begin
      m4 <= model_next(m4, 4, 2);
      m8 <= model_next(m8, 8, 300);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("u4.cnt_val", int'(cnt4), m4.cnt);
    check("u4.co", int'(co4), int'(model_term(m4, 4)));
    check("u4.wrap", int'(wrap4), int'(m4.wr));
    check("u4.done", int'(done4), int'(m4.halted));
    check("u8.cnt_val", int'(cnt8), m8.cnt);
    check("u8.co", int'(co8), int'(model_term(m8, 8)));
    check("u8.wrap", int'(wrap8), int'(m8.wr));
    check("u8.done", int'(done8), int'(m8.halted));
  end

  task automatic step(input logic i_iz, input logic i_ld, input logic [7:0] i_ldv,
                      input logic i_cen);
    iz = i_iz;
    ld = i_ld;
    ld_val = i_ldv;
    cen = i_cen;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sat_exp[5];
    sclr = 1'b0; cen = 1'b0; iz = 1'b0; ld = 1'b0; ld_val = '0;
    up = 1'b1; mode = 2'd0; term = 8'd15;
    #2 sclr = 1'b1;
    #1;
    check("reset cnt", int'(cnt4), 0);
    check("reset done", int'(done4), 0);
    check("reset wrap", int'(wrap8), 0);
    @(posedge clk);
    #1 sclr = 1'b0;

    // Legacy 4-bit behaviour: init 2, terminal at 15, wrap to 0.
    step(1, 0, 0, 0);
    check("legacy init", int'(cnt4), 2);
    for (int i = 0; i < 13; i++) step(0, 0, 0, 1);
    check("legacy cnt15", int'(cnt4), 15);
    check("legacy co", int'(co4), 1);
    step(0, 0, 0, 1);
    check("legacy wrap cnt", int'(cnt4), 0);
    check("legacy wrap pulse", int'(wrap4), 1);
    check("legacy co after", int'(co4), 0);
    step(0, 0, 0, 0);
    check("legacy wrap one cycle", int'(wrap4), 0);

    // Down counting with wrap to term.
    up = 1'b0; term = 8'd9;
    step(0, 1, 8'd2, 0);
    step(0, 0, 0, 1);
    check("down 1", int'(cnt8), 1);
    step(0, 0, 0, 1);
    check("down 0", int'(cnt8), 0);
    check("down co", int'(co8), 1);
    step(0, 0, 0, 1);
    check("down wrap cnt", int'(cnt8), 9);
    check("down wrap pulse", int'(wrap8), 1);

    // Saturate.
    up = 1'b1; mode = 2'd1; term = 8'd5;
    sat_exp = '{4, 5, 5, 5, 5};
    step(0, 1, 8'd3, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1);
      check("sat cnt", int'(cnt8), sat_exp[i]);
      check("sat wrap", int'(wrap8), 0);
    end
    check("sat co", int'(co8), 1);

    // One-shot.
    mode = 2'd2; term = 8'd3;
    step(0, 1, 8'd0, 0);
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 0, 1);
      check("oneshot cnt", int'(cnt8), i);
    end
    step(0, 0, 0, 1);
    check("oneshot hold", int'(cnt8), 3);
    check("oneshot wrap", int'(wrap8), 1);
    check("oneshot done", int'(done8), 1);
    step(0, 0, 0, 1);
    check("halt cnt", int'(cnt8), 3);
    check("halt wrap", int'(wrap8), 0);
    check("halt done", int'(done8), 1);
    step(0, 1, 8'd1, 0);
    check("reload cnt", int'(cnt8), 1);
    check("reload done", int'(done8), 0);
    step(0, 0, 0, 1);
    check("resume cnt", int'(cnt8), 2);

    // Priority at terminal and loaded values above term.
    mode = 2'd0; term = 8'd7;
    step(0, 1, 8'd7, 0);
    step(1, 1, 8'd5, 1);
    check("prio u4", int'(cnt4), 2);
    check("prio u8", int'(cnt8), 44);
    check("prio wrap", int'(wrap4), 0);
    step(0, 1, 8'd12, 0);
    check("above term co", int'(co8), 1);
    step(0, 0, 0, 1);
    check("above term wrap cnt", int'(cnt8), 0);
    check("above term wrap", int'(wrap8), 1);

    // Asynchronous reset while halted with wrap high.
    mode = 2'd2; term = 8'd6;
    step(0, 1, 8'd4, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("pre-reset cnt", int'(cnt8), 6);
    check("pre-reset done", int'(done8), 1);
    cen = 1'b0;
    #2 sclr = 1'b1;
    #1;
    check("async cnt", int'(cnt8), 0);
    check("async done", int'(done8), 0);
    check("async wrap", int'(wrap8), 0);
    #2 sclr = 1'b0;
    step(0, 0, 0, 1);
    check("post-reset cnt", int'(cnt8), 1);

    // Randomized phase.
    for (int n = 0; n < 3000; n++) begin
      up = 1'($urandom_range(0, 1));
      mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0)
        term = 8'($urandom_range(0, 255));
      else if ($urandom_range(0, 9) == 0)
        term = 8'($urandom_range(0, 15));
      step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) == 0),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 9) < 7));
      if ($urandom_range(0, 59) == 0) begin
        #1 sclr = 1'b1;
        #1 sclr = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
